// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the LC-3 register file write port,
// with per-requester lock and a one-entry registered issue stage.
module regfile_write_arbiter #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_lock,
  input  logic [3*N_REQ-1:0]     req_addr,
  input  logic [WIDTH*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [7:0]             rf_wr_en,
  output logic [WIDTH-1:0]       rf_d,
  output logic [7:0]             rf_pending
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    lock_owner;
  logic             lock_active;
  logic             iss_valid;
  logic [2:0]       iss_addr;
  logic [WIDTH-1:0] iss_data;

  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [2:0]       sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic             sel_lock;

  // A held lock excludes everyone else, even while its owner is idle.
  always_comb begin
    int idx;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    idx       = 0;
    if (!rst && !stall) begin
      if (lock_active) begin
        if (req_valid[lock_owner]) begin
          gnt_any = 1'b1;
          gnt_idx = lock_owner;
        end
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = (int'(rr_ptr) + k) % N_REQ;
          if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = PW'(idx);
          end
        end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_addr = req_addr[3*i +: 3];
        sel_data = req_data[WIDTH*i +: WIDTH];
        sel_lock = req_lock[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      lock_owner  <= '0;
      lock_active <= 1'b0;
      iss_valid   <= 1'b0;
      iss_addr    <= '0;
      iss_data    <= '0;
    end else begin
      iss_valid <= gnt_any;
      if (gnt_any) begin
        iss_addr <= sel_addr;
        iss_data <= sel_data;
        if (sel_lock) begin
          lock_active <= 1'b1;
          lock_owner  <= gnt_idx;
        end else begin
          lock_active <= 1'b0;
          rr_ptr      <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  assign rf_wr_en   = iss_valid ? (8'd1 << iss_addr) : 8'd0;
  assign rf_d       = iss_data;
  assign rf_pending = rf_wr_en;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the LC-3 register file (eight `register` instances, WIDTH bits each) among several writers: datapath writeback, interrupt/trap unit (R6/R7 saves), and debug monitor. Accepts one write per cycle via valid/ready handshakes using round-robin priority. Supports a per-requester lock for atomic multi-write sequences. Drives the per-register write enables and shared data bus through a one-entry registered issue stage.

## Interface
- WIDTH, 16, data width of each register
- N_REQ, 3, number of requesters; index 0 is writeback, 1 is interrupt unit, 2 is debug
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  control FSM hold; blocks new grants while high
- req_valid  in  N_REQ  requester i has a write pending
- req_lock  in  N_REQ  requester i keeps ownership after this transfer
- req_addr  in  3*N_REQ  target register for requester i, bits [3i+2:3i]
- req_data  in  WIDTH*N_REQ  write data for requester i, bits [WIDTH*i+WIDTH-1:WIDTH*i]
- req_ready  out  N_REQ  grant; a transfer occurs when req_valid[i] & req_ready[i]
- rf_wr_en  out  8  one-hot write enable, bit k drives `wr_en` of register Rk
- rf_d  out  WIDTH  shared `d_i` bus to all eight registers
- rf_pending  out  8  one-hot; register k has an accepted write not yet committed

## Operation
- State:
  - rr_ptr: requester index with top priority, 0..N_REQ-1
  - lock_active and lock_owner
  - Issue stage: iss_valid, iss_addr, iss_data
- Grant, combinational:
  - If rst or stall is high, req_ready is all zero.
  - If lock_active is set, only lock_owner may be granted. Others get ready=0 even when the owner is idle.
  - Otherwise grant the first valid requester found scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - At most one req_ready bit is high. req_ready may depend on req_valid.
- On a transfer from requester g:
  - iss_valid<=1, iss_addr<=req_addr[g], iss_data<=req_data[g].
  - Pointer and lock:
    - If req_lock[g] is high: lock_active<=1, lock_owner<=g, rr_ptr unchanged.
    - If req_lock[g] is low: lock_active<=0, rr_ptr<=(g+1) mod N_REQ.
- With no transfer, iss_valid<=0. rr_ptr and lock hold.
- Issue stage outputs:
  - rf_wr_en = iss_valid ? (1<<iss_addr) : 0
  - rf_d = iss_data
  - rf_pending = rf_wr_en
- Stall never cancels the issue stage; an accepted write always commits.
- Back-to-back writes to the same register both commit, in acceptance order.
- req_lock is ignored when no transfer occurs; lock release happens only via a transfer with lock low.

## Timing
- Reset values, applied asynchronously and held while rst=1:
  - req_ready=0, rf_wr_en=0, rf_d=0, rf_pending=0
  - rr_ptr=0, lock_active=0, iss_valid=0, iss_addr=0, iss_data=0
- Reset mid-lock or mid-issue drops the lock and the in-flight write (no commit).
- Latency: transfer on edge N. rf_wr_en is high during cycle N+1. Register Rk holds the new data after edge N+1. Total 2 edges from acceptance to visible register output.
- Throughput: one write per cycle sustained. The issue stage never back-pressures.
- Simultaneous events:
  - stall and lock together: no grant, lock retained.
  - Owner deasserts valid while locked: no grants to anyone until the owner transfers with lock low or reset.
- Wrap-around: rr_ptr=N_REQ-1 granted without lock gives rr_ptr=0.

## Test plan
- Reset: assert rst asynchronously mid-cycle with iss_valid=1 -> rf_wr_en=0 immediately, R3 unchanged. After release, rr_ptr=0 and ready follows priority 0,1,2.
- Single write: req 0 writes R2=0x1234 -> req_ready[0]=1 same cycle. rf_wr_en=0x04 and rf_d=0x1234 next cycle. R2 reads 0x1234 after the following edge.
- Round-robin fairness: all three valid continuously with distinct addresses -> grant order 0,1,2,0,1,2. rf_wr_en is one-hot every cycle.
- Lock: req 1 writes R6=0x2FFE lock=1, then R7=0x3000 lock=0, while req 0 and req 2 are valid -> only req 1 is granted for both writes. Next grant goes to req 2.
- Stall: stall=1 for 3 cycles with req 2 valid -> req_ready=0. A write accepted the cycle before stall still commits. Grant resumes the cycle stall falls.
- Same-register back-to-back: req 0 writes R5=0x0001, then R5=0x0002 -> R5 ends at 0x0002. rf_pending[5] is high for both issue cycles.
